// File: rtl/int_mult_pkg.sv
// Shared sizing helpers for the pipelined integer multiplier.
// Chunk count, product width, term count and CSA tree depth/shape as constant functions.
// Pure compile-time content, no logic.
package int_mult_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_CHUNK_W = 16;
    localparam int NUM_CHUNKS  = DEF_DATA_W / DEF_CHUNK_W;
    localparam int PROD_W      = 2 * DEF_DATA_W;

    function automatic int num_chunks(input int data_w, input int chunk_w);
        return data_w / chunk_w;
    endfunction

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Chunk partial products plus two sign-correction terms
    function automatic int num_terms(input int nc);
        return nc * nc + 2;
    endfunction

    // Number of live terms after lvl levels of 3:2 compression
    function automatic int csa_level_terms(input int n0, input int lvl);
        int n;
        n = n0;
        for (int i = 0; i < lvl; i++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + (n % 3);
            end
        end
        return n;
    endfunction

    // Levels needed to reduce n0 terms down to a carry/save pair
    function automatic int csa_depth(input int n0);
        int n;
        int d;
        n = n0;
        d = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + (n % 3);
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/int_mult_pipe_csa_3to2.sv
// 3:2 carry-save compressor: three addends in, carry and save vectors out.
// Latency: combinational.
// Backpressure: none, pure datapath.
module csa_3to2
    import int_mult_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [W-1:0] in_z,
    output logic [W-1:0] carry,
    output logic [W-1:0] save
);

    logic [W-1:0] maj;

    // Bitwise sum and majority; carry is pre-shifted to its weight, top bit dropped (mod 2^W)
    assign save  = in_x ^ in_y ^ in_z;
    assign maj   = (in_x & in_y) | (in_x & in_z) | (in_y & in_z);
    assign carry = maj << 1;

endmodule

// File: rtl/int_mult_pipe.sv
// Pipelined DATA_W x DATA_W integer multiplier (signed/unsigned) with tag sideband;
// optional accumulate mode under macro INT_MULT_MAC_EN. Latency: 3 cycles, 1 op/cycle.
// Backpressure: global stall of all three stages while the output is held and not accepted.
module int_mult_pipe
    import int_mult_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16,
    parameter int TAG_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic                  in_signed,
    input  logic [TAG_W-1:0]      in_tag,
`ifdef INT_MULT_MAC_EN
    input  logic                  in_acc,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_p,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int NC    = num_chunks(DATA_W, CHUNK_W);
    localparam int PW    = prod_w(DATA_W);
    localparam int NT    = num_terms(NC);
    localparam int DEPTH = csa_depth(NT);

    logic              stall;
    logic              accept;
    logic              s1_vld, s2_vld, s3_vld;
    logic [TAG_W-1:0]  s1_tag, s2_tag;
    logic [PW-1:0]     term_d [NT];
    logic [PW-1:0]     s1_term [NT];
    logic [PW-1:0]     lvl_t [DEPTH+1][NT];
    logic [PW-1:0]     s2_carry, s2_save;
    logic [PW-1:0]     sum_d;
    logic [DATA_W-1:0] neg_a, neg_b;

    assign stall     = s3_vld & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = s3_vld;

    // ---------------- S1 inputs: chunk partial products at their weight ----------------
    for (genvar i = 0; i < NC; i++) begin : g_ca
        for (genvar j = 0; j < NC; j++) begin : g_cb
            logic [2*CHUNK_W-1:0] pp;
            assign pp = in_a[i*CHUNK_W +: CHUNK_W] * in_b[j*CHUNK_W +: CHUNK_W];
            assign term_d[i*NC+j] = PW'(pp) << ((i + j) * CHUNK_W);
        end
    end

    // Signed correction: a_s*b_s = A*B - a_msb*B*2^W - b_msb*A*2^W (mod 2^2W).
    // -(X*2^W) mod 2^2W equals ((-X) mod 2^W) placed in the upper half.
    assign neg_a = ~in_a + DATA_W'(1);
    assign neg_b = ~in_b + DATA_W'(1);
    assign term_d[NT-2] = (in_signed & in_a[DATA_W-1]) ? {neg_b, {DATA_W{1'b0}}} : '0;
    assign term_d[NT-1] = (in_signed & in_b[DATA_W-1]) ? {neg_a, {DATA_W{1'b0}}} : '0;

    // Stage valid bits: advance together unless the output is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
        end else if (!stall) begin
            s1_vld <= accept;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
        end
    end

    // S1/S2 data registers (no reset needed, qualified by the valid bits)
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_term  <= term_d;
            s1_tag   <= in_tag;
            s2_carry <= lvl_t[DEPTH][0];
            s2_save  <= lvl_t[DEPTH][1];
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- CSA tree between S1 and S2 ----------------
    for (genvar j = 0; j < NT; j++) begin : g_l0
        assign lvl_t[0][j] = s1_term[j];
    end

    for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
        localparam int NP = csa_level_terms(NT, l - 1);
        localparam int NG = NP / 3;
        localparam int NN = csa_level_terms(NT, l);
        for (genvar k = 0; k < NG; k++) begin : g_csa
            csa_3to2 #(.W(PW)) u_csa (
                .in_x  (lvl_t[l-1][3*k]),
                .in_y  (lvl_t[l-1][3*k+1]),
                .in_z  (lvl_t[l-1][3*k+2]),
                .carry (lvl_t[l][2*k]),
                .save  (lvl_t[l][2*k+1])
            );
        end
        for (genvar j = 2 * NG; j < NT; j++) begin : g_pass
            if (j < NN) begin : g_fwd
                assign lvl_t[l][j] = lvl_t[l-1][3*NG + j - 2*NG];
            end else begin : g_zero
                assign lvl_t[l][j] = '0;
            end
        end
    end

    // ---------------- S3: final carry-propagate add ----------------
`ifdef INT_MULT_MAC_EN
    logic          s1_acc, s2_acc;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_src;

    // Accumulate flag follows its operation through S1/S2
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_acc <= in_acc;
            s2_acc <= s1_acc;
        end
    end

    // acc tracks the most recently delivered result
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (s3_vld && out_ready) begin
            acc <= out_p;
        end
    end

    // When S3 advances while holding a result, that result is being delivered now: forward it
    assign acc_src = s3_vld ? out_p : acc;
    assign sum_d   = s2_carry + s2_save + (s2_acc ? acc_src : '0);
`else
    assign sum_d   = s2_carry + s2_save;
`endif

    // Output register: loads only real results, holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_p   <= '0;
            out_tag <= '0;
        end else if (!stall && s2_vld) begin
            out_p   <= sum_d;
            out_tag <= s2_tag;
        end
    end

endmodule

// File: tb/tb_int_mult_pipe.sv
// Directed-vector bench for int_mult_pipe: table vectors, 32-bit build vector,
// randomly back-pressured streaming, mid-flight reset, accumulate sequence.
// Runs to a single summary line.
module tb_int_mult_pipe;

    localparam int DW = 64;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [DW-1:0]   in_a, in_b;
    logic [TW-1:0]   in_tag, out_tag;
    logic [2*DW-1:0] out_p;

    logic            d32_in_valid, d32_in_ready, d32_in_signed, d32_out_valid;
    logic [31:0]     d32_in_a, d32_in_b;
    logic [TW-1:0]   d32_in_tag, d32_out_tag;
    logic [63:0]     d32_out_p;
`ifdef INT_MULT_MAC_EN
    logic            in_acc;
    logic            d32_in_acc;
`endif

    always #5 clk = ~clk;

    int_mult_pipe #(.DATA_W(DW), .CHUNK_W(16), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
`ifdef INT_MULT_MAC_EN
        .in_acc(in_acc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
    );

    int_mult_pipe #(.DATA_W(32), .CHUNK_W(16), .TAG_W(TW)) dut32 (
        .clk(clk), .reset(reset), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
        .in_a(d32_in_a), .in_b(d32_in_b), .in_signed(d32_in_signed), .in_tag(d32_in_tag),
`ifdef INT_MULT_MAC_EN
        .in_acc(d32_in_acc),
`endif
        .out_valid(d32_out_valid), .out_ready(1'b1), .out_p(d32_out_p), .out_tag(d32_out_tag)
    );

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic         sgn;
        logic [3:0]   tag;
        logic [127:0] p;
    } vec_t;

    typedef struct packed {
        logic [127:0] p;
        logic [3:0]   tag;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [127:0] xa, xb;
        xa = s ? {{64{a[63]}}, a} : {64'b0, a};
        xb = s ? {{64{b[63]}}, b} : {64'b0, b};
        return xa * xb;
    endfunction

    // One isolated op: accepted at edge E0, must be absent after E1, present after E2
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_signed = v.sgn; in_tag = v.tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({nm, "_early_vld"}, 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        check({nm, "_vld"}, 128'(out_valid), 128'd1);
        check({nm, "_p"},   out_p, v.p);
        check({nm, "_tag"}, 128'(out_tag), 128'(v.tag));
    endtask

    vec_t vecs[13];

    initial begin
        exp_t         q[$];
        exp_t         e;
        int           sent, recv, cyc;
        logic         held, acc_now;
        logic [127:0] held_p;
        logic [3:0]   held_tag;

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd3,
                     128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 4'd5,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd6,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[3]  = '{64'd0, 64'hDEAD_BEEF_1234_5678, 1'b0, 4'd0, 128'd0};
        vecs[4]  = '{64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 4'd7,
                     128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd8, 128'd1};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'd2, 1'b0, 4'd9,
                     128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vecs[7]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd10,
                     128'h0000_0000_0000_0000_8000_0000_0000_0000};
        vecs[8]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 4'd11,
                     128'hC000_0000_0000_0000_8000_0000_0000_0000};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 4'd12,
                     128'h7FFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
        vecs[10] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 4'd13,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
        vecs[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd14,
                     128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
        vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 4'd15,
                     128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_signed = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        d32_in_valid = 1'b0; d32_in_signed = 1'b0; d32_in_a = '0; d32_in_b = '0; d32_in_tag = '0;
`ifdef INT_MULT_MAC_EN
        in_acc = 1'b0; d32_in_acc = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready",  128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_p",     out_p, 128'd0);
        check("rst_out_tag",   128'(out_tag), 128'd0);

        // Table-driven directed vectors
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // 32-bit build
        @(negedge clk);
        d32_in_a = 32'h1234_5678; d32_in_b = 32'h9ABC_DEF0; d32_in_tag = 4'd9; d32_in_valid = 1'b1;
        @(posedge clk); #1;
        d32_in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("w32_vld", 128'(d32_out_valid), 128'd1);
        check("w32_p",   128'(d32_out_p), 128'(64'h0B00_EA4E_242D_2080));
        check("w32_tag", 128'(d32_out_tag), 128'd9);

        // Streaming with random backpressure
        sent = 0; recv = 0; cyc = 0; held = 1'b0; held_p = '0; held_tag = '0;
        in_valid = 1'b0;
        while (recv < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                in_a      = {$urandom, $urandom};
                in_b      = {$urandom, $urandom};
                in_signed = 1'($urandom_range(0, 1));
                in_tag    = 4'($urandom_range(0, 15));
                in_valid  = 1'b1;
            end
            #1;
            if (held) begin
                check("stall_vld", 128'(out_valid), 128'd1);
                check("stall_p",   out_p, held_p);
                check("stall_tag", 128'(out_tag), 128'(held_tag));
            end
            held     = out_valid && !out_ready;
            held_p   = out_p;
            held_tag = out_tag;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_vld", 128'(out_valid), 128'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("stream%0d_p", recv),   out_p, e.p);
                    check($sformatf("stream%0d_tag", recv), 128'(out_tag), 128'(e.tag));
                    recv++;
                end
            end
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                q.push_back('{ref_mul(in_a, in_b, in_signed), in_tag});
                sent++;
            end
            @(posedge clk); #1;
            if (acc_now) in_valid = 1'b0;
        end
        if (recv < 100) check("stream_timeout_recv", 128'(recv), 128'd100);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_a = 64'(k + 5); in_b = 64'd7; in_signed = 1'b0; in_tag = 4'(k + 1); in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_p",     out_p, 128'd0);
        check("midrst_out_tag",   128'(out_tag), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_stale%0d", k), 128'(out_valid), 128'd0);
        end
        run_vec(vecs[8], "postrst");

`ifdef INT_MULT_MAC_EN
        // Back-to-back accumulate chain: 12, 12+30, 42+1
        begin
            logic [63:0]  ma [3];
            logic [63:0]  mb [3];
            logic         mc [3];
            logic [127:0] mexp [3];
            ma = '{64'd3, 64'd5, 64'd1};
            mb = '{64'd4, 64'd6, 64'd1};
            mc = '{1'b0, 1'b1, 1'b1};
            mexp = '{128'd12, 128'd42, 128'd43};
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                out_ready = 1'b1;
                if (k < 3) begin
                    in_a = ma[k]; in_b = mb[k]; in_acc = mc[k]; in_signed = 1'b0;
                    in_tag = 4'(k); in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0; in_acc = 1'b0;
                end
                @(posedge clk); #1;
                if (k >= 2) begin
                    check($sformatf("mac%0d_vld", k - 2), 128'(out_valid), 128'd1);
                    check($sformatf("mac%0d_p", k - 2),   out_p, mexp[k-2]);
                end
            end
            in_valid = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_mult_pipe.md
INT_MULT_PIPE -- requirements
Module: int_mult_pipe

Interface
REQ-001: Parameter DATA_W, default 64, operand width in bits; SHALL be a multiple of CHUNK_W, range 16..256.
REQ-002: Parameter CHUNK_W, default 16, partial-product chunk width (one DSP multiply per chunk pair).
REQ-003: Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-004: clk  input  1  single clock; all logic rising-edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: in_valid  input  1  operand pair present.
REQ-007: in_ready  output  1  block accepts operands this cycle.
REQ-008: in_a, in_b  input  DATA_W each  operands.
REQ-009: in_signed  input  1  0 = unsigned product, 1 = two's-complement product.
REQ-010: in_tag  input  TAG_W  returned unchanged with the result.
REQ-011: out_valid  output  1  result present.
REQ-012: out_ready  input  1  consumer accepts result.
REQ-013: out_p  output  2*DATA_W  product.
REQ-014: out_tag  output  TAG_W  tag of the product on out_p.

Function
REQ-015: Accept occurs on in_valid & in_ready; deliver occurs on out_valid & out_ready.
REQ-016: Three-stage pipeline: S1 registers all NUM_CHUNKS^2 chunk products shifted to their weight; S2 registers carry/save vectors from the CSA tree; S3 registers carry+save sum as out_p.
REQ-017: Latency: operands accepted at cycle N SHALL appear on out_p with out_valid=1 at cycle N+3 when out_ready is held high.
REQ-018: Throughput: one accept per cycle with no bubbles while out_ready=1.
REQ-019: Backpressure: in_ready = ~S3_valid | out_ready; when in_ready=0, all stages hold (global stall), no data lost or duplicated.
REQ-020: A stalled out_p/out_tag SHALL remain stable until delivered.
REQ-021: Unsigned result = in_a*in_b exact, 2*DATA_W bits.
REQ-022: Signed result = exact two's-complement product of sign-interpreted operands in 2*DATA_W bits; sign correction SHALL be applied in S1 (subtract sign-weighted operand terms), not by post-negation.
REQ-023: Bubbles (no accept) SHALL propagate as invalid stages; out_valid only for accepted operations, in accept order.
REQ-024: Simultaneous deliver and accept in the full-pipeline state SHALL advance all stages in the same cycle.

Reset
REQ-025: While reset=1 at a clock edge, all stage valid bits clear; out_valid=0, out_p=0, out_tag=0; in_ready=1 in the first cycle after reset.
REQ-026: Reset mid-operation discards all in-flight operations; none are delivered afterward.
REQ-027: Data registers other than outputs need no reset.

Configuration
REQ-028: Macro INT_MULT_MAC_EN compiles in accumulate mode.
REQ-029: With INT_MULT_MAC_EN: extra input in_acc (1 bit) and internal register acc (2*DATA_W, reset 0); for an operation with in_acc=1, out_p = product + acc mod 2^(2*DATA_W); with in_acc=0, out_p = product; acc loads out_p on every deliver; added in S3 using the result delivered immediately before.
REQ-030: With INT_MULT_MAC_EN, a back-to-back accumulate whose predecessor is still in S3 SHALL forward the S3 value (no extra stall, latency unchanged).
REQ-031: Without INT_MULT_MAC_EN: no in_acc port, no acc register; behaviour per REQ-015..027 only.

Structure
REQ-032: Package int_mult_pkg holds NUM_CHUNKS=DATA_W/CHUNK_W, CSA tree depth function, and product-width constant.
REQ-033: One sub-module csa_3to2 (3 inputs, carry and save outputs, parameterised width); tree built by generate instances.

Verification
REQ-034: Unsigned 64-bit: a=0xFFFF_FFFF_FFFF_FFFF, b=same, tag=3 -> at N+3 out_p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, out_tag=3.
REQ-035: Signed: a=-1, b=2 -> out_p=all-ones minus 1 (-2); a=0x8000_0000_0000_0000, b=same -> out_p=0x4000_0000_0000_0000_0000_0000_0000_0000.
REQ-036: Streaming 100 random pairs, out_ready toggled pseudo-randomly 50% -> all 100 results correct, in order, tags matching, stalled outputs stable.
REQ-037: Reset asserted with 3 in flight -> next cycle out_valid=0, no stale result ever appears; new op after reset correct at N+3.
REQ-038: With INT_MULT_MAC_EN: ops (3*4, acc=0),(5*6, acc=1),(1*1, acc=1) back-to-back -> outputs 12, 42, 43.
REQ-039: DATA_W=32, CHUNK_W=16 build: 0x1234_5678*0x9ABC_DEF0 -> 0x0B00_EA4E_242D_2080.
